// File: rtl/dmac_cfg_mc_if.sv
// APB slave bus bundle for the DMA configuration block.
// Signal names keep the original port names so existing fabric wiring maps 1:1.
interface dmac_cfg_mc_if;
    logic        psel_i;
    logic        penable_i;
    logic [11:0] paddr_i;
    logic        pwrite_i;
    logic [31:0] pwdata_i;
    logic        pready_o;
    logic [31:0] prdata_o;
    logic        pslverr_o;

    modport master (
        output psel_i, penable_i, paddr_i, pwrite_i, pwdata_i,
        input  pready_o, prdata_o, pslverr_o
    );

    modport slave (
        input  psel_i, penable_i, paddr_i, pwrite_i, pwdata_i,
        output pready_o, prdata_o, pslverr_o
    );
endinterface

// File: rtl/dmac_cfg_mc.sv
// APB register block for the multi-channel DMA controller.
// Global page 0x000: VERSION, INT_STATUS (W1C), INT_EN.
// Channel n page 0x100*(n+1): SRC, DST, LEN, CMD (start), STATUS.
// Decode and error are resolved in the APB setup phase; writes commit in the
// access phase. Writes to a busy channel are rejected with PSLVERR.
// Optional build macro DMAC_CFG_ALIGN_CHECK_EN: reject start commands whose
// SRC/DST/LEN are not word aligned or whose LEN is zero.
module dmac_cfg_mc #(
    parameter int unsigned CH_CNT  = 4,
    parameter int unsigned LEN_W   = 16,
    parameter logic [31:0] VERSION = 32'h0002_0000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    dmac_cfg_mc_if.slave            apb,
    output logic [CH_CNT*32-1:0]    src_addr_o,
    output logic [CH_CNT*32-1:0]    dst_addr_o,
    output logic [CH_CNT*LEN_W-1:0] byte_len_o,
    output logic [CH_CNT-1:0]       start_o,
    input  logic [CH_CNT-1:0]       done_i,
    output logic                    irq_o
);

    typedef enum logic [3:0] {
        REG_NONE,
        REG_VERSION,
        REG_INT_STATUS,
        REG_INT_EN,
        REG_SRC,
        REG_DST,
        REG_LEN,
        REG_CMD,
        REG_STATUS
    } reg_sel_e;

    logic [31:0]       src_q [CH_CNT];
    logic [31:0]       dst_q [CH_CNT];
    logic [LEN_W-1:0]  len_q [CH_CNT];
    logic [CH_CNT-1:0] int_status_q;
    logic [CH_CNT-1:0] int_en_q;
    logic [CH_CNT-1:0] done_q;

    logic [3:0]        page;
    logic [7:0]        offs;
    reg_sel_e          sel;
    logic [CH_CNT-1:0] ch_hit;
    logic              busy;
    logic              err;
    logic [31:0]       rdata;
    logic              setup;
    logic              wr_en;
    logic [CH_CNT-1:0] rise;
    logic [CH_CNT-1:0] clr;

    assign page         = apb.paddr_i[11:8];
    assign offs         = apb.paddr_i[7:0];
    assign setup        = apb.psel_i & ~apb.penable_i;
    // pslverr_o holds the setup-phase verdict throughout the access phase
    assign wr_en        = apb.psel_i & apb.penable_i & apb.pwrite_i & ~apb.pslverr_o;
    assign apb.pready_o = 1'b1;
    assign busy         = |(ch_hit & ~done_i);
    assign rise         = done_i & ~done_q;

    // Address decode: register kind plus one-hot channel select
    always_comb begin
        sel    = REG_NONE;
        ch_hit = '0;
        if (page == 4'd0) begin
            unique case (offs)
                8'h00:   sel = REG_VERSION;
                8'h04:   sel = REG_INT_STATUS;
                8'h08:   sel = REG_INT_EN;
                default: sel = REG_NONE;
            endcase
        end else begin
            for (int unsigned n = 0; n < CH_CNT; n++) begin
                if (page == 4'(n + 1)) begin
                    ch_hit[n] = 1'b1;
                    unique case (offs)
                        8'h00:   sel = REG_SRC;
                        8'h04:   sel = REG_DST;
                        8'h08:   sel = REG_LEN;
                        8'h0C:   sel = REG_CMD;
                        8'h10:   sel = REG_STATUS;
                        default: sel = REG_NONE;
                    endcase
                end
            end
        end
    end

`ifdef DMAC_CFG_ALIGN_CHECK_EN
    logic [CH_CNT-1:0] misaligned;
    logic [31:0]       len_ext [CH_CNT];

    // Per-channel start legality: word-aligned addresses and a non-zero word-multiple length
    always_comb begin
        for (int unsigned n = 0; n < CH_CNT; n++) begin
            len_ext[n]              = '0;
            len_ext[n][LEN_W-1:0]   = len_q[n];
            misaligned[n] = (src_q[n][1:0] != 2'b00) || (dst_q[n][1:0] != 2'b00) ||
                            (len_ext[n][1:0] != 2'b00) || (len_ext[n] == 32'd0);
        end
    end
`endif

    // Access legality: unmapped, RO write, CMD read, busy-channel write
    always_comb begin
        err = 1'b0;
        unique case (sel)
            REG_NONE:                   err = 1'b1;
            REG_VERSION, REG_STATUS:    err = apb.pwrite_i;
            REG_INT_STATUS, REG_INT_EN: err = 1'b0;
            REG_SRC, REG_DST, REG_LEN:  err = apb.pwrite_i & busy;
            REG_CMD:                    err = ~apb.pwrite_i | busy;
            default:                    err = 1'b1;
        endcase
`ifdef DMAC_CFG_ALIGN_CHECK_EN
        if (sel == REG_CMD && apb.pwrite_i && apb.pwdata_i[0] && |(ch_hit & misaligned)) begin
            err = 1'b1;
        end
`endif
    end

    // Read data mux; unused bits are zero
    always_comb begin
        rdata = '0;
        unique case (sel)
            REG_VERSION:    rdata = VERSION;
            REG_INT_STATUS: rdata[CH_CNT-1:0] = int_status_q;
            REG_INT_EN:     rdata[CH_CNT-1:0] = int_en_q;
            REG_STATUS:     rdata[1:0] = {busy, |(ch_hit & done_i)};
            default: begin
                for (int unsigned n = 0; n < CH_CNT; n++) begin
                    if (ch_hit[n]) begin
                        if (sel == REG_SRC) rdata = src_q[n];
                        if (sel == REG_DST) rdata = dst_q[n];
                        if (sel == REG_LEN) rdata[LEN_W-1:0] = len_q[n];
                    end
                end
            end
        endcase
    end

    // Setup-phase capture of read data and error; error drops outside the access phase
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            apb.prdata_o  <= '0;
            apb.pslverr_o <= 1'b0;
        end else if (setup) begin
            apb.pslverr_o <= err;
            if (!apb.pwrite_i) begin
                apb.prdata_o <= err ? 32'd0 : rdata;
            end
        end else begin
            apb.pslverr_o <= 1'b0;
        end
    end

    // Channel register write commit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned n = 0; n < CH_CNT; n++) begin
                src_q[n] <= '0;
                dst_q[n] <= '0;
                len_q[n] <= '0;
            end
        end else if (wr_en) begin
            for (int unsigned n = 0; n < CH_CNT; n++) begin
                if (ch_hit[n]) begin
                    if (sel == REG_SRC) src_q[n] <= apb.pwdata_i;
                    if (sel == REG_DST) dst_q[n] <= apb.pwdata_i;
                    if (sel == REG_LEN) len_q[n] <= apb.pwdata_i[LEN_W-1:0];
                end
            end
        end
    end

    assign clr = (wr_en && sel == REG_INT_STATUS) ? apb.pwdata_i[CH_CNT-1:0] : '0;

    // Done edge capture, sticky status (set beats W1C clear), enable and registered irq
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done_q       <= '1;
            int_status_q <= '0;
            int_en_q     <= '0;
            irq_o        <= 1'b0;
        end else begin
            done_q       <= done_i;
            int_status_q <= (int_status_q & ~clr) | rise;
            if (wr_en && sel == REG_INT_EN) begin
                int_en_q <= apb.pwdata_i[CH_CNT-1:0];
            end
            irq_o <= |(int_status_q & int_en_q);
        end
    end

    // Start pulse in the access cycle of an accepted CMD write with bit0 set
    always_comb begin
        start_o = '0;
        if (wr_en && sel == REG_CMD && apb.pwdata_i[0]) begin
            start_o = ch_hit;
        end
    end

    // Flatten channel registers onto the packed output buses
    always_comb begin
        src_addr_o = '0;
        dst_addr_o = '0;
        byte_len_o = '0;
        for (int unsigned n = 0; n < CH_CNT; n++) begin
            src_addr_o[n*32 +: 32]       = src_q[n];
            dst_addr_o[n*32 +: 32]       = dst_q[n];
            byte_len_o[n*LEN_W +: LEN_W] = len_q[n];
        end
    end

endmodule
